serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder with carry in/out: a + b + carry_in, one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Inverse-direction companion to the combinational full subtractor: recovers a minuend from difference + subtrahend (a = diff + b + borrow chain).
- Sits in the arithmetic exercise set as the first sequential datapath block.
- Uses a start/busy/done handshake so a bench or controller can drive it.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- carry_in  input  1  initial carry; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result is valid
- sum  output  WIDTH  result; held until next accepted start completes
- carry_out  output  1  final carry; held with sum

Behaviour:
- Reset: one clock, asynchronous and active-low. rst_n low immediately forces:
  - state IDLE
  - busy=0, done=0, sum=0, carry_out=0
  - internal shift registers, carry flop and bit counter cleared
- Reset mid-RUN aborts the operation. No done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E → load a_sh=a, b_sh=b, carry=carry_in, cnt=0, sum_sh=0; go to RUN. start=0 → stay.
  - RUN: each edge computes one full-adder bit:
    - s = a_sh[0] ^ b_sh[0] ^ carry
    - c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0]))
    - shift a_sh, b_sh right; shift s into sum_sh MSB; carry=c; cnt=cnt+1
    - On the edge where cnt==WIDTH-1, i.e. the last bit: write sum=final sum_sh and carry_out=c; go to DONE.
  - DONE: done=1 for exactly this one cycle; next edge → IDLE unconditionally.
- Latency: start accepted at edge E; busy=1 during cycles after edges E..E+WIDTH-1; done=1 in the cycle after edge E+WIDTH. Throughput: one result per WIDTH+2 cycles including the IDLE sample.
- busy is registered: high from the cycle after the accepting edge until the transition to DONE.
- start in RUN or DONE is ignored and not queued. Changes to a, b or carry_in after capture have no effect.
- sum and carry_out change only at the final RUN edge. Outside that edge they hold the last result, including through IDLE.
- WIDTH=1: RUN lasts exactly one edge.
- Arithmetic is modulo 2^WIDTH on sum. carry_out is bit WIDTH of the full-precision result.
- Counter width: $clog2(WIDTH) with a minimum of 1 bit. No wrap beyond WIDTH-1.
- Unused state encodings recover to IDLE.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit), signed two's-complement overflow of a + b + carry_in.
  - overflow = carry into MSB XOR carry out of MSB, captured at the final RUN edge.
  - Held with sum; reset to 0.
- Undefined: no overflow port, no related logic. All other behaviour identical.

Test Plan:
- WIDTH=4, a=5, b=3, carry_in=0, start pulse one cycle → busy for 4 cycles, then done pulse; sum=8, carry_out=0.
- a=15, b=1, carry_in=0 → sum=0, carry_out=1. Then a=7, b=8, carry_in=1 → sum=0, carry_out=1.
- Exhaustive a, b in 0..15 with carry_in in {0,1} (512 runs) → {carry_out, sum} == a+b+carry_in for every case.
- Start a=2, b=2. Two cycles into RUN, change a=9 and pulse start again → second start ignored; result sum=4; exactly one done pulse.
- Start a=6, b=6. Drop rst_n during the 2nd RUN cycle → immediately busy=0, sum=0, carry_out=0, no done pulse. After release, a=1, b=1 → sum=2.
- SERIAL_ADDER_OVF_EN defined, a=7, b=1 → sum=8, overflow=1. Then a=15, b=1 → sum=0, carry_out=1, overflow=0.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder (a + b + carry_in), LSB first; optional overflow output under SERIAL_ADDER_OVF_EN
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    // bit counter needs at least one bit even when WIDTH == 1
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_next;

    // single full-adder cell working on the current LSBs and the carry flop
    assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    // result bits enter at the MSB so the LSB-first stream lands in place
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next = fa_s;
        end else begin : g_sum_wn
            assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // control FSM plus datapath registers; all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= carry_in;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= fa_c;
                    if (cnt == CNT_LAST) begin
                        sum       <= sum_next;
                        carry_out <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry flop holds the carry into the MSB on this edge
                        overflow  <= carry ^ fa_c;
`endif
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
